mem_bus_arbiter: RTL and testbench

//  Two-master, one-transaction-at-a-time controller in front of the MCU memory map.
//  M0 is instruction fetch; M1 is data load/store.

---
 rtl/mem_pkg.sv | 26 ++
 rtl/address_decoder.sv | 23 ++
 rtl/mem_rr_arbiter.sv | 19 +
 rtl/mem_bus_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared constants for the memory-bus arbiter: region tags, region indices,
// FSM encoding and master indices.
package mem_pkg;

    localparam logic [15:0] REG_BRAM   = 16'h0000;
    localparam logic [15:0] REG_SRAM   = 16'h0001;
    localparam logic [15:0] REG_FLASH  = 16'h0002;
    localparam logic [15:0] REG_PERIPH = 16'h0003;

    localparam int IDX_BRAM   = 0;
    localparam int IDX_SRAM   = 1;
    localparam int IDX_FLASH  = 2;
    localparam int IDX_PERIPH = 3;

    localparam int WAIT_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/address_decoder.sv
// Maps the upper address half onto a one-hot region select; anything above
// the peripheral region is reported as unmapped.
module address_decoder
    import mem_pkg::*;
(
    input  logic [15:0] addr_hi,
    output logic [3:0]  sel,
    output logic        err
);

    always_comb begin
        sel = '0;
        err = 1'b0;
        case (addr_hi)
            REG_BRAM:   sel[IDX_BRAM]   = 1'b1;
            REG_SRAM:   sel[IDX_SRAM]   = 1'b1;
            REG_FLASH:  sel[IDX_FLASH]  = 1'b1;
            REG_PERIPH: sel[IDX_PERIPH] = 1'b1;
            default:    err             = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the master
// that was not granted last. Output is meaningless when req is 0.
module mem_rr_arbiter
    import mem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant
);

    always_comb begin
        case (req)
            2'b01:   grant = M0;
            2'b10:   grant = M1;
            default: grant = ~last_grant;
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master, one-transaction-at-a-time front end for the MCU memory map:
// round-robin grant, region decode, per-region wait states, single-cycle ack.
module mem_bus_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned BRAM_WAIT   = 0,
    parameter int unsigned SRAM_WAIT   = 1,
    parameter int unsigned FLASH_WAIT  = 4,
    parameter int unsigned PERIPH_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  m_req,
    input  logic [63:0] m_addr,
    input  logic [1:0]  m_we,
    input  logic [7:0]  m_be,
    input  logic [63:0] m_wdata,
    output logic [1:0]  m_ack,
    output logic [1:0]  m_err,
    output logic [31:0] m_rdata,
    output logic [3:0]  mem_sel,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    if (BRAM_WAIT > 7 || SRAM_WAIT > 7 || FLASH_WAIT > 7 || PERIPH_WAIT > 7) begin : g_wait_check
        $error("mem_bus_arbiter: WAIT parameters must fit the 3-bit wait counter");
    end

    localparam logic [WAIT_W-1:0] W_BRAM   = WAIT_W'(BRAM_WAIT);
    localparam logic [WAIT_W-1:0] W_SRAM   = WAIT_W'(SRAM_WAIT);
    localparam logic [WAIT_W-1:0] W_FLASH  = WAIT_W'(FLASH_WAIT);
    localparam logic [WAIT_W-1:0] W_PERIPH = WAIT_W'(PERIPH_WAIT);

    state_t              state_q, state_d;
    logic                grant_q, grant_d;
    logic                last_q, last_d;
    logic [WAIT_W-1:0]   wait_q, wait_d, wait_sel;
    logic                pick;
    logic [31:0]         req_addr, req_wdata;
    logic                req_we;
    logic [3:0]          req_be;
    logic [3:0]          dec_sel;
    logic                dec_err;
    logic [1:0]          m_ack_d, m_err_d;
    logic [31:0]         m_rdata_d, mem_addr_d, mem_wdata_d;
    logic [3:0]          mem_sel_d, mem_be_d;
    logic                mem_we_d;

    mem_rr_arbiter u_rr (
        .req        (m_req),
        .last_grant (last_q),
        .grant      (pick)
    );

    assign req_addr  = pick ? m_addr[63:32]  : m_addr[31:0];
    assign req_wdata = pick ? m_wdata[63:32] : m_wdata[31:0];
    assign req_we    = pick ? m_we[1]        : m_we[0];
    assign req_be    = pick ? m_be[7:4]      : m_be[3:0];

    address_decoder u_dec (
        .addr_hi (req_addr[31:16]),
        .sel     (dec_sel),
        .err     (dec_err)
    );

    always_comb begin
        wait_sel = '0;
        if (dec_sel[IDX_SRAM])   wait_sel = W_SRAM;
        if (dec_sel[IDX_FLASH])  wait_sel = W_FLASH;
        if (dec_sel[IDX_PERIPH]) wait_sel = W_PERIPH;
        if (dec_sel[IDX_BRAM])   wait_sel = W_BRAM;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= M0;
            last_q    <= M1;
            wait_q    <= '0;
            m_ack     <= '0;
            m_err     <= '0;
            m_rdata   <= '0;
            mem_sel   <= '0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_wdata <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            wait_q    <= wait_d;
            m_ack     <= m_ack_d;
            m_err     <= m_err_d;
            m_rdata   <= m_rdata_d;
            mem_sel   <= mem_sel_d;
            mem_addr  <= mem_addr_d;
            mem_we    <= mem_we_d;
            mem_be    <= mem_be_d;
            mem_wdata <= mem_wdata_d;
        end
    end

    // Outputs are computed for the state being entered so every port is a flop.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        wait_d      = wait_q;
        m_ack_d     = '0;
        m_err_d     = '0;
        m_rdata_d   = '0;
        mem_sel_d   = mem_sel;
        mem_addr_d  = mem_addr;
        mem_we_d    = mem_we;
        mem_be_d    = mem_be;
        mem_wdata_d = mem_wdata;
        case (state_q)
            IDLE: begin
                if (|m_req) begin
                    grant_d     = pick;
                    last_d      = pick;
                    mem_addr_d  = req_addr;
                    mem_we_d    = req_we;
                    mem_be_d    = req_be;
                    mem_wdata_d = req_wdata;
                    if (dec_err) begin
                        mem_sel_d      = '0;
                        m_ack_d[pick]  = 1'b1;
                        m_err_d[pick]  = 1'b1;
                        state_d        = RESP;
                    end else begin
                        mem_sel_d = dec_sel;
                        wait_d    = wait_sel;
                        state_d   = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (wait_q != '0) begin
                    wait_d = wait_q - 3'd1;
                end else begin
                    mem_sel_d        = '0;
                    m_ack_d[grant_q] = 1'b1;
                    m_rdata_d        = mem_we ? 32'h0 : mem_rdata;
                    state_d          = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                mem_sel_d = '0;
                state_d   = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: vector table of single transactions plus
// hand-written sequences for round-robin, async reset abort and dropped request.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  m_req;
    logic [63:0] m_addr;
    logic [1:0]  m_we;
    logic [7:0]  m_be;
    logic [63:0] m_wdata;
    logic [1:0]  m_ack;
    logic [1:0]  m_err;
    logic [31:0] m_rdata;
    logic [3:0]  mem_sel;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    mem_bus_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m_req     (m_req),
        .m_addr    (m_addr),
        .m_we      (m_we),
        .m_be      (m_be),
        .m_wdata   (m_wdata),
        .m_ack     (m_ack),
        .m_err     (m_err),
        .m_rdata   (m_rdata),
        .mem_sel   (mem_sel),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        m;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] srd;
        logic [3:0]  sel;
        int          nsel;
        int          lat;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Counts cycles after the sampling edge until m_ack shows, recording the
    // first mem_sel cycle's bus fields and the ack-cycle response.
    task automatic wait_ack(input int limit, output int cyc, output int nsel,
                            output logic [3:0] sel1, output logic [31:0] a1,
                            output logic we1, output logic [3:0] be1,
                            output logic [31:0] wd1, output logic [1:0] ack,
                            output logic [1:0] err, output logic [31:0] rd,
                            output logic timed_out);
        cyc = 0; nsel = 0; sel1 = '0; a1 = '0; we1 = 1'b0; be1 = '0; wd1 = '0;
        ack = '0; err = '0; rd = '0; timed_out = 1'b1;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (mem_sel != 4'b0) begin
                if (nsel == 0) begin
                    sel1 = mem_sel; a1 = mem_addr; we1 = mem_we; be1 = mem_be; wd1 = mem_wdata;
                end
                nsel++;
            end
            if (m_ack != 2'b0) begin
                ack = m_ack; err = m_err; rd = m_rdata; timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        m_req = 2'b00;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
    endtask

    int          cyc, nsel;
    logic [3:0]  sel1, be1;
    logic [31:0] a1, wd1, rd;
    logic        we1, to;
    logic [1:0]  ack, err, exp_ack;

    initial begin
        rst_n = 1'b0; m_req = '0; m_addr = '0; m_we = '0; m_be = '0; m_wdata = '0; mem_rdata = '0;

        //          m     addr          we    be       wdata         srd           sel      nsel lat err  rdata
        vecs[0] = '{1'b0, 32'h0000_0010, 1'b0, 4'b1111, 32'h0,        32'hDEAD_BEEF, 4'b0001, 1, 2, 1'b0, 32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 32'h0002_0000, 1'b1, 4'b0011, 32'h0000_1234, 32'h5555_AAAA, 4'b0100, 5, 6, 1'b0, 32'h0};
        vecs[2] = '{1'b0, 32'h0004_0000, 1'b0, 4'b1111, 32'h0,        32'h7777_7777, 4'b0000, 0, 1, 1'b1, 32'h0};
        vecs[3] = '{1'b1, 32'h0001_0004, 1'b0, 4'b1100, 32'h0,        32'hCAFE_F00D, 4'b0010, 2, 3, 1'b0, 32'hCAFE_F00D};
        vecs[4] = '{1'b0, 32'h0003_0100, 1'b1, 4'b0001, 32'h0000_00A5, 32'h1111_2222, 4'b1000, 2, 3, 1'b0, 32'h0};
        vecs[5] = '{1'b1, 32'hFFFF_0000, 1'b1, 4'b1111, 32'hABCD_0000, 32'h3333_4444, 4'b0000, 0, 1, 1'b1, 32'h0};
        vecs[6] = '{1'b1, 32'h0002_0040, 1'b0, 4'b1111, 32'h0,        32'h1234_5678, 4'b0100, 5, 6, 1'b0, 32'h1234_5678};

        #12;
        check("rst_ack",   {62'h0, m_ack}, 64'h0);
        check("rst_sel",   {60'h0, mem_sel}, 64'h0);
        check("rst_rdata", {32'h0, m_rdata}, 64'h0);
        check("rst_addr",  {32'h0, mem_addr}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            m_req     = vecs[i].m ? 2'b10 : 2'b01;
            m_addr    = vecs[i].m ? {vecs[i].addr, 32'h0BAD_0BAD} : {32'h0BAD_0BAD, vecs[i].addr};
            m_wdata   = vecs[i].m ? {vecs[i].wdata, 32'h5A5A_5A5A} : {32'h5A5A_5A5A, vecs[i].wdata};
            m_we      = vecs[i].m ? {vecs[i].we, 1'b0} : {1'b0, vecs[i].we};
            m_be      = vecs[i].m ? {vecs[i].be, 4'b0} : {4'b0, vecs[i].be};
            mem_rdata = vecs[i].srd;
            wait_ack(12, cyc, nsel, sel1, a1, we1, be1, wd1, ack, err, rd, to);
            m_req = 2'b00;
            exp_ack = vecs[i].m ? 2'b10 : 2'b01;
            check($sformatf("v%0d_timeout", i), {63'h0, to}, 64'h0);
            check($sformatf("v%0d_lat", i), 64'(cyc), 64'(vecs[i].lat));
            check($sformatf("v%0d_ack", i), {62'h0, ack}, {62'h0, exp_ack});
            check($sformatf("v%0d_err", i), {62'h0, err}, vecs[i].err ? {62'h0, exp_ack} : 64'h0);
            check($sformatf("v%0d_rdata", i), {32'h0, rd}, {32'h0, vecs[i].rdata});
            check($sformatf("v%0d_nsel", i), 64'(nsel), 64'(vecs[i].nsel));
            if (vecs[i].sel != 4'b0) begin
                check($sformatf("v%0d_sel", i), {60'h0, sel1}, {60'h0, vecs[i].sel});
                check($sformatf("v%0d_addr", i), {32'h0, a1}, {32'h0, vecs[i].addr});
                check($sformatf("v%0d_we", i), {63'h0, we1}, {63'h0, vecs[i].we});
                check($sformatf("v%0d_be", i), {60'h0, be1}, {60'h0, vecs[i].be});
                check($sformatf("v%0d_wdata", i), {32'h0, wd1}, {32'h0, vecs[i].wdata});
            end
            @(posedge clk);
        end

        // Both masters held high: strict alternation starting with M0.
        do_reset();
        m_req = 2'b11; m_addr = {32'h0000_0200, 32'h0000_0100};
        m_we = 2'b00; m_be = 8'hFF; mem_rdata = 32'h0F0F_0F0F;
        for (int t = 0; t < 4; t++) begin
            wait_ack(12, cyc, nsel, sel1, a1, we1, be1, wd1, ack, err, rd, to);
            if (t == 3) m_req = 2'b00;
            check($sformatf("rr%0d_ack", t), {62'h0, ack}, (t % 2 == 0) ? 64'h1 : 64'h2);
            check($sformatf("rr%0d_lat", t), 64'(cyc), (t == 0) ? 64'd2 : 64'd3);
            check($sformatf("rr%0d_addr", t), {32'h0, a1}, (t % 2 == 0) ? 64'h100 : 64'h200);
        end
        @(posedge clk);

        // Reset asserted mid-cycle during FLASH ACCESS aborts the transaction.
        @(negedge clk);
        m_req = 2'b01; m_addr = {32'h0, 32'h0002_0040}; mem_rdata = 32'h9999_9999;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_mid_sel_before", {60'h0, mem_sel}, 64'h4);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_sel", {60'h0, mem_sel}, 64'h0);
        check("rst_async_ack", {62'h0, m_ack}, 64'h0);
        m_req = 2'b00;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check($sformatf("rst_noack%0d", k), {62'h0, m_ack}, 64'h0);
        end
        @(negedge clk);
        m_req = 2'b11; m_addr = {32'h0000_0008, 32'h0000_0004};
        wait_ack(12, cyc, nsel, sel1, a1, we1, be1, wd1, ack, err, rd, to);
        m_req = 2'b00;
        check("post_rst_ack", {62'h0, ack}, 64'h1);
        check("post_rst_lat", 64'(cyc), 64'd2);
        @(posedge clk);

        // M0 drops its request mid-SRAM access while M1 starts requesting.
        @(negedge clk);
        m_req = 2'b01; m_addr = {32'h0000_0300, 32'h0001_0020}; mem_rdata = 32'hBEEF_0001;
        @(posedge clk); #1;
        m_req = 2'b10;
        wait_ack(12, cyc, nsel, sel1, a1, we1, be1, wd1, ack, err, rd, to);
        check("drop_ack", {62'h0, ack}, 64'h1);
        check("drop_lat", 64'(cyc + 1), 64'd3);
        check("drop_rdata", {32'h0, rd}, 64'hBEEF_0001);
        wait_ack(12, cyc, nsel, sel1, a1, we1, be1, wd1, ack, err, rd, to);
        m_req = 2'b00;
        check("next_ack", {62'h0, ack}, 64'h2);
        check("next_lat", 64'(cyc), 64'd3);
        check("next_sel", {60'h0, sel1}, 64'h1);
        check("next_addr", {32'h0, a1}, 64'h300);
        @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
